adc_scan_motor_pwm: RTL and testbench

ADC_SCAN_MOTOR_PWM -- requirements
Module: adc_scan_motor_pwm

---
 rtl/adc_scan_motor_pwm.sv | 276 +++++++++++++++++++++++++++
 tb/tb_adc_scan_motor_pwm.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_motor_pwm.sv
// -----------------------------------------------------------------------------
// adc_scan_motor_pwm
//   Scans ADC0809 channels round-robin, keeps one 8-bit sample per channel,
//   subtracts a DIP-switch offset from the selected channel (saturating at 0)
//   and drives a DC motor H-bridge with a glitch-free 8-bit PWM plus a
//   one-period dead time on every direction reversal.
//
// Ports
//   clk          in   system clock (rising edge)
//   reset        in   synchronous active-high reset
//   eoc          in   ADC end-of-conversion (asynchronous, synchronised here)
//   result[7:0]  in   ADC data bus, sampled while out_en=1
//   dip_sw[7:0]  in   offset subtracted from the selected sample
//   ch_sel[2:0]  in   channel driving the motor (>=CH_NUM selects 0)
//   dir          in   requested direction, 0 forward / 1 reverse
//   addr[2:0]    out  ADC mux address
//   ale,start,out_en,adc_clk  out  ADC0809 control
//   pwm_out      out  motor enable PWM
//   motor_dir    out  H-bridge {in1,in2}
//   level[7:0]   out  saturated (sample - dip_sw)
//   sample_valid out  one-cycle pulse per captured sample
//   timeout_err  out  sticky EOC timeout flag
// -----------------------------------------------------------------------------
module adc_scan_motor_pwm #(
  parameter int CH_NUM      = 4,
  parameter int CLK_DIV     = 25,
  parameter int PULSE_W     = 4,
  parameter int EOC_TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       eoc,
  input  logic [7:0] result,
  input  logic [7:0] dip_sw,
  input  logic [2:0] ch_sel,
  input  logic       dir,
  output logic [2:0] addr,
  output logic       ale,
  output logic       start,
  output logic       out_en,
  output logic       adc_clk,
  output logic       pwm_out,
  output logic [1:0] motor_dir,
  output logic [7:0] level,
  output logic       sample_valid,
  output logic       timeout_err
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int PW = $clog2(PULSE_W + 1);
  localparam int TW = $clog2(EOC_TIMEOUT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [PW-1:0] PW_LAST  = PW'(PULSE_W - 1);
  localparam logic [PW-1:0] PW_ONE   = PW'(1);
  localparam logic [TW-1:0] TO_LAST  = TW'(EOC_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE   = TW'(1);
  localparam logic [2:0]    IDX_LAST = 3'(CH_NUM - 1);
  localparam logic [3:0]    CH_NUM_W = 4'(CH_NUM);

  typedef enum logic [2:0] {
    S_ADDR    = 3'd0,
    S_ALE     = 3'd1,
    S_START   = 3'd2,
    S_WAIT_LO = 3'd3,
    S_WAIT_HI = 3'd4,
    S_READ    = 3'd5,
    S_NEXT    = 3'd6
  } state_t;

  state_t          state_q;
  logic [2:0]      idx_q;
  logic [PW-1:0]   pcnt_q;
  logic [TW-1:0]   to_cnt_q;
  logic            ale_q, start_q, out_en_q, sample_valid_q, timeout_err_q;
  logic [7:0]      sample_q [0:7];
  logic [DW-1:0]   div_q;
  logic            adc_clk_q;
  logic            eoc_s1_q, eoc_s2_q;
  logic [7:0]      pwm_cnt_q, duty_q;
  logic            dir_q, applied_dir_q, pwm_q;
  logic [1:0]      motor_dir_q;

  logic [2:0]      sel_idx_s;
  logic [7:0]      sel_sample_s, level_s;
  logic [7:0]      cnt_d, duty_d;
  logic            applied_dir_d, pwm_d;
  logic [1:0]      motor_dir_d;

  // Free-running ADC clock divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      adc_clk_q <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q     <= '0;
      adc_clk_q <= ~adc_clk_q;
    end else begin
      div_q     <= div_q + DIV_ONE;
    end
  end

  // Two-flop synchroniser for the asynchronous eoc input.
  always_ff @(posedge clk) begin
    if (reset) begin
      eoc_s1_q <= 1'b0;
      eoc_s2_q <= 1'b0;
    end else begin
      eoc_s1_q <= eoc;
      eoc_s2_q <= eoc_s1_q;
    end
  end

  // Conversion sequencer; the timeout counter spans both EOC wait states.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_ADDR;
      idx_q          <= 3'd0;
      pcnt_q         <= '0;
      to_cnt_q       <= '0;
      ale_q          <= 1'b0;
      start_q        <= 1'b0;
      out_en_q       <= 1'b0;
      sample_valid_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      for (int i = 0; i < 8; i++) sample_q[i] <= 8'd0;
    end else begin
      sample_valid_q <= 1'b0;
      case (state_q)
        S_ADDR: begin
          ale_q   <= 1'b1;
          pcnt_q  <= '0;
          state_q <= S_ALE;
        end
        S_ALE: begin
          if (pcnt_q == PW_LAST) begin
            ale_q   <= 1'b0;
            start_q <= 1'b1;
            pcnt_q  <= '0;
            state_q <= S_START;
          end else begin
            pcnt_q  <= pcnt_q + PW_ONE;
          end
        end
        S_START: begin
          if (pcnt_q == PW_LAST) begin
            start_q  <= 1'b0;
            to_cnt_q <= '0;
            state_q  <= S_WAIT_LO;
          end else begin
            pcnt_q   <= pcnt_q + PW_ONE;
          end
        end
        S_WAIT_LO: begin
          if (to_cnt_q == TO_LAST) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_NEXT;
          end else begin
            to_cnt_q <= to_cnt_q + TO_ONE;
            if (!eoc_s2_q) state_q <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          // A conversion finishing on the very last allowed cycle still counts.
          if (eoc_s2_q) begin
            out_en_q <= 1'b1;
            pcnt_q   <= '0;
            state_q  <= S_READ;
          end else if (to_cnt_q == TO_LAST) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_NEXT;
          end else begin
            to_cnt_q <= to_cnt_q + TO_ONE;
          end
        end
        S_READ: begin
          if (pcnt_q == PW_LAST) begin
            sample_q[idx_q] <= result;
            sample_valid_q  <= 1'b1;
            out_en_q        <= 1'b0;
            state_q         <= S_NEXT;
          end else begin
            pcnt_q <= pcnt_q + PW_ONE;
          end
        end
        S_NEXT: begin
          idx_q   <= (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
          state_q <= S_ADDR;
        end
        default: begin
          ale_q    <= 1'b0;
          start_q  <= 1'b0;
          out_en_q <= 1'b0;
          state_q  <= S_ADDR;
        end
      endcase
    end
  end

  // Channel select and saturating offset subtraction.
  always_comb begin
    sel_idx_s = 3'd0;
    if ({1'b0, ch_sel} < CH_NUM_W) begin
      sel_idx_s = ch_sel;
    end else begin
      sel_idx_s = 3'd0;
    end
    sel_sample_s = sample_q[sel_idx_s];
    if (sel_sample_s > dip_sw) begin
      level_s = sel_sample_s - dip_sw;
    end else begin
      level_s = 8'd0;
    end
  end

  // PWM next state: duty and direction only move at the period boundary.
  // A reversal first spends a whole period at duty 0 before the new
  // direction is allowed to drive the bridge.
  always_comb begin
    cnt_d         = pwm_cnt_q + 8'd1;
    duty_d        = duty_q;
    applied_dir_d = applied_dir_q;
    if (pwm_cnt_q == 8'hFF) begin
      if (dir_q != applied_dir_q) begin
        duty_d        = 8'd0;
        applied_dir_d = dir_q;
      end else begin
        duty_d        = level_s;
        applied_dir_d = applied_dir_q;
      end
    end else begin
      duty_d        = duty_q;
      applied_dir_d = applied_dir_q;
    end
    if (duty_d == 8'd0) begin
      motor_dir_d = 2'b00;
    end else if (applied_dir_d) begin
      motor_dir_d = 2'b01;
    end else begin
      motor_dir_d = 2'b10;
    end
    // pwm_q is computed for the counter value it will be shown alongside.
    pwm_d = (cnt_d < duty_d);
  end

  // PWM and direction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q     <= 8'd0;
      duty_q        <= 8'd0;
      dir_q         <= 1'b0;
      applied_dir_q <= 1'b0;
      pwm_q         <= 1'b0;
      motor_dir_q   <= 2'b00;
    end else begin
      pwm_cnt_q     <= cnt_d;
      duty_q        <= duty_d;
      dir_q         <= dir;
      applied_dir_q <= applied_dir_d;
      pwm_q         <= pwm_d;
      motor_dir_q   <= motor_dir_d;
    end
  end

  assign addr         = idx_q;
  assign ale          = ale_q;
  assign start        = start_q;
  assign out_en       = out_en_q;
  assign adc_clk      = adc_clk_q;
  assign pwm_out      = pwm_q;
  assign motor_dir    = motor_dir_q;
  assign level        = level_s;
  assign sample_valid = sample_valid_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_adc_scan_motor_pwm.sv
module tb_adc_scan_motor_pwm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       eoc;
  logic [7:0] result;
  logic [7:0] dip_sw = 8'd0;
  logic [2:0] ch_sel = 3'd0;
  logic       dir = 1'b0;
  logic [2:0] addr;
  logic       ale, start, out_en, adc_clk, pwm_out, sample_valid, timeout_err;
  logic [1:0] motor_dir;
  logic [7:0] level;

  int tests = 0;
  int fails = 0;

  adc_scan_motor_pwm dut (
    .clk(clk), .reset(reset), .eoc(eoc), .result(result), .dip_sw(dip_sw),
    .ch_sel(ch_sel), .dir(dir), .addr(addr), .ale(ale), .start(start),
    .out_en(out_en), .adc_clk(adc_clk), .pwm_out(pwm_out),
    .motor_dir(motor_dir), .level(level), .sample_valid(sample_valid),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // ADC0809 model: eoc drops while start is high, rises 20 cycles later.
  logic       eoc_r = 1'b1;
  int         conv_cnt = 0;
  logic       eoc_stuck = 1'b0;
  logic       ovr_en = 1'b0;
  logic [7:0] ovr_val = 8'd0;
  always @(posedge clk) begin
    if (start) begin
      eoc_r    <= 1'b0;
      conv_cnt <= 20;
    end else if (conv_cnt != 0) begin
      conv_cnt <= conv_cnt - 1;
      if (conv_cnt == 1) eoc_r <= 1'b1;
    end
  end
  assign eoc    = eoc_stuck ? 1'b0 : eoc_r;
  assign result = out_en ? (ovr_en ? ovr_val : 8'h10 * ({5'd0, addr} + 8'd1)) : 8'h00;

  // Expected PWM counter and cycles since reset.
  logic [7:0] tb_cnt;
  int         tb_cyc;
  always @(posedge clk) begin
    if (reset) begin
      tb_cnt <= 8'd0;
      tb_cyc <= 0;
    end else begin
      tb_cnt <= tb_cnt + 8'd1;
      tb_cyc <= tb_cyc + 1;
    end
  end

  task automatic wait_cnt(input logic [7:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (tb_cnt == v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic measure_period(input logic [7:0] exp_duty, input logic [1:0] exp_dir,
                                output int highs, output int perr, output int derr);
    highs = 0; perr = 0; derr = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pwm_out === 1'b1) highs++;
      if (pwm_out !== (tb_cnt < exp_duty)) perr++;
      if (motor_dir !== exp_dir) derr++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (addr !== 3'd0) begin fails++; $display("FAIL reset_addr: got %0d want 0", addr); end
    tests++; if ({ale, start, out_en, adc_clk} !== 4'b0000) begin fails++; $display("FAIL reset_adc_ctrl: got %b want 0000", {ale, start, out_en, adc_clk}); end
    tests++; if ({pwm_out, motor_dir} !== 3'b000) begin fails++; $display("FAIL reset_motor: got %b want 000", {pwm_out, motor_dir}); end
    tests++; if ({sample_valid, timeout_err} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b want 00", {sample_valid, timeout_err}); end
    tests++; if (level !== 8'd0) begin fails++; $display("FAIL reset_level: got %h want 00", level); end
    reset = 1'b0;
  endtask

  task automatic test_scan();
    logic [2:0] seq [5];
    int         n_ale, n_sv, cyc;
    logic       prev_ale, exp_clk;
    logic [2:0] t_ch  [5];
    logic [7:0] t_dip [5];
    logic [7:0] t_exp [5];
    n_ale = 0; n_sv = 0; cyc = 0; prev_ale = 1'b0;
    for (int i = 0; i < 5; i++) seq[i] = 3'bxxx;
    while (n_ale < 5 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (tb_cyc == 24 || tb_cyc == 25 || tb_cyc == 50) begin
        exp_clk = (tb_cyc == 25);
        tests++; if (adc_clk !== exp_clk) begin fails++; $display("FAIL adc_clk_div: cycle %0d got %b want %b", tb_cyc, adc_clk, exp_clk); end
      end
      if (ale && !prev_ale) begin
        seq[n_ale] = addr;
        n_ale++;
      end
      prev_ale = ale;
      if (sample_valid) n_sv++;
    end
    tests++; if (n_ale != 5) begin fails++; $display("FAIL scan_budget: saw %0d ale pulses want 5", n_ale); end
    for (int i = 0; i < 5; i++) begin
      tests++; if (seq[i] !== 3'(i % 4)) begin fails++; $display("FAIL scan_addr[%0d]: got %0d want %0d", i, seq[i], i % 4); end
    end
    tests++; if (n_sv != 4) begin fails++; $display("FAIL scan_valid_count: got %0d want 4", n_sv); end
    t_ch[0] = 3'd2; t_dip[0] = 8'h00; t_exp[0] = 8'h30;
    t_ch[1] = 3'd3; t_dip[1] = 8'h00; t_exp[1] = 8'h40;
    t_ch[2] = 3'd5; t_dip[2] = 8'h00; t_exp[2] = 8'h10;
    t_ch[3] = 3'd2; t_dip[3] = 8'h30; t_exp[3] = 8'h00;
    t_ch[4] = 3'd2; t_dip[4] = 8'h10; t_exp[4] = 8'h20;
    for (int i = 0; i < 5; i++) begin
      ch_sel = t_ch[i]; dip_sw = t_dip[i];
      #1;
      tests++; if (level !== t_exp[i]) begin fails++; $display("FAIL level[%0d]: ch %0d dip %h got %h want %h", i, t_ch[i], t_dip[i], level, t_exp[i]); end
    end
  endtask

  task automatic test_pwm();
    bit ok;
    int h, pe, de;
    ch_sel = 3'd2; dip_sw = 8'h10;
    wait_cnt(8'hFF, ok);
    tests++; if (!ok) begin fails++; $display("FAIL pwm_sync: counter boundary not reached"); end
    measure_period(8'd32, 2'b10, h, pe, de);
    tests++; if (h != 32 || pe != 0 || de != 0) begin fails++; $display("FAIL pwm_duty32: highs %0d posErr %0d dirErr %0d want 32/0/0", h, pe, de); end
    dip_sw = 8'h50;
    #1;
    tests++; if (level !== 8'h00) begin fails++; $display("FAIL level_saturate: got %h want 00", level); end
    measure_period(8'd0, 2'b00, h, pe, de);
    tests++; if (h != 0 || pe != 0 || de != 0) begin fails++; $display("FAIL pwm_duty0: highs %0d posErr %0d dirErr %0d want 0/0/0", h, pe, de); end
  endtask

  task automatic test_dir_change();
    bit ok;
    int h, pe, de, cyc;
    ovr_val = 8'h80; ovr_en = 1'b1; dip_sw = 8'h00; ch_sel = 3'd3; dir = 1'b0;
    cyc = 0; ok = 1'b0;
    while (!ok && cyc < 600) begin
      @(negedge clk); cyc++;
      if (sample_valid && addr == 3'd3) ok = 1'b1;
    end
    tests++; if (!ok) begin fails++; $display("FAIL dir_capture: no sample on channel 3"); end
    @(negedge clk);
    tests++; if (level !== 8'h80) begin fails++; $display("FAIL dir_level: got %h want 80", level); end
    wait_cnt(8'hFF, ok);
    measure_period(8'd128, 2'b10, h, pe, de);
    tests++; if (h != 128 || pe != 0 || de != 0) begin fails++; $display("FAIL fwd_128: highs %0d posErr %0d dirErr %0d want 128/0/0", h, pe, de); end
    wait_cnt(8'd100, ok);
    dir = 1'b1;
    wait_cnt(8'hFF, ok);
    measure_period(8'd0, 2'b00, h, pe, de);
    tests++; if (h != 0 || pe != 0 || de != 0) begin fails++; $display("FAIL dead_time_rev: highs %0d posErr %0d dirErr %0d want 0/0/0", h, pe, de); end
    measure_period(8'd128, 2'b01, h, pe, de);
    tests++; if (h != 128 || pe != 0 || de != 0) begin fails++; $display("FAIL rev_128: highs %0d posErr %0d dirErr %0d want 128/0/0", h, pe, de); end
    // Direction and level change together: dead time first, new level after.
    wait_cnt(8'd100, ok);
    dir = 1'b0; dip_sw = 8'h40;
    #1;
    tests++; if (level !== 8'h40) begin fails++; $display("FAIL dir_level2: got %h want 40", level); end
    wait_cnt(8'hFF, ok);
    measure_period(8'd0, 2'b00, h, pe, de);
    tests++; if (h != 0 || pe != 0 || de != 0) begin fails++; $display("FAIL dead_time_fwd: highs %0d posErr %0d dirErr %0d want 0/0/0", h, pe, de); end
    measure_period(8'd64, 2'b10, h, pe, de);
    tests++; if (h != 64 || pe != 0 || de != 0) begin fails++; $display("FAIL fwd_64: highs %0d posErr %0d dirErr %0d want 64/0/0", h, pe, de); end
  endtask

  task automatic test_timeout();
    int         cyc, n, sv, oe;
    bit         ok;
    logic [2:0] k;
    logic       prev_ale;
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL timeout_pre: got %b want 0", timeout_err); end
    cyc = 0; ok = 1'b0; k = 3'd0;
    while (!ok && cyc < 200) begin
      @(negedge clk); cyc++;
      if (sample_valid) begin ok = 1'b1; k = (addr == 3'd3) ? 3'd0 : addr + 3'd1; end
    end
    eoc_stuck = 1'b1; ovr_val = 8'hEE;
    cyc = 0;
    while (start !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    tests++; if (start !== 1'b1 || addr !== k) begin fails++; $display("FAIL timeout_start: start %b addr %0d want 1/%0d", start, addr, k); end
    cyc = 0;
    while (start !== 1'b0 && cyc < 20) begin @(negedge clk); cyc++; end
    n = 0; sv = 0; oe = 0;
    while (timeout_err !== 1'b1 && n < 5000) begin
      @(negedge clk); n++;
      if (sample_valid) sv++;
      if (out_en) oe++;
    end
    tests++; if (n != 4096) begin fails++; $display("FAIL timeout_cycles: got %0d want 4096", n); end
    tests++; if (sv != 0 || oe != 0) begin fails++; $display("FAIL timeout_no_read: sample_valid %0d out_en %0d want 0/0", sv, oe); end
    eoc_stuck = 1'b0; ch_sel = k; dip_sw = 8'h00;
    #1;
    tests++; if (level !== 8'h80) begin fails++; $display("FAIL timeout_keep_sample: got %h want 80", level); end
    cyc = 0; prev_ale = ale;
    while (!(ale && !prev_ale) && cyc < 50) begin prev_ale = ale; @(negedge clk); cyc++; end
    tests++; if (addr !== ((k == 3'd3) ? 3'd0 : k + 3'd1)) begin fails++; $display("FAIL timeout_next_ch: got %0d", addr); end
    tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL timeout_sticky: got %b want 1", timeout_err); end
  endtask

  task automatic test_reset_mid();
    int   cyc, sv;
    bit   ok;
    logic prev_ale;
    ovr_en = 1'b0; ch_sel = 3'd2; dip_sw = 8'h00;
    cyc = 0;
    while (start !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    while (start !== 1'b0 && cyc < 120) begin @(negedge clk); cyc++; end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++; if (addr !== 3'd0) begin fails++; $display("FAIL mid_reset_addr: got %0d want 0", addr); end
    tests++; if ({ale, start, out_en, adc_clk} !== 4'b0000) begin fails++; $display("FAIL mid_reset_adc_ctrl: got %b want 0000", {ale, start, out_en, adc_clk}); end
    tests++; if ({pwm_out, motor_dir} !== 3'b000) begin fails++; $display("FAIL mid_reset_motor: got %b want 000", {pwm_out, motor_dir}); end
    tests++; if ({sample_valid, timeout_err} !== 2'b00) begin fails++; $display("FAIL mid_reset_flags: got %b want 00", {sample_valid, timeout_err}); end
    tests++; if (level !== 8'd0) begin fails++; $display("FAIL mid_reset_level: got %h want 00", level); end
    reset = 1'b0;
    cyc = 0; sv = 0; prev_ale = 1'b0; ok = 1'b0;
    while (!ok && cyc < 50) begin
      @(negedge clk); cyc++;
      if (sample_valid) sv++;
      if (ale && !prev_ale) ok = 1'b1;
      prev_ale = ale;
    end
    tests++; if (!ok || addr !== 3'd0 || sv != 0) begin fails++; $display("FAIL mid_reset_restart: ale %b addr %0d valids %0d want 1/0/0", ok, addr, sv); end
    cyc = 0;
    while (sample_valid !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    ch_sel = 3'd0;
    #1;
    tests++; if (sample_valid !== 1'b1 || addr !== 3'd0 || level !== 8'h10) begin fails++; $display("FAIL mid_reset_first_sample: valid %b addr %0d level %h want 1/0/10", sample_valid, addr, level); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_pwm();
    test_dir_change();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
